// File: rtl/nco_i2c_regfile.sv
// nco_i2c_regfile: I2C slave (clk, async rst, scl, open-drain sda) holding per-channel NCO shadow regs, committed to enable/wave/frequency/duty_cycle with cfg_update on STOP; busy spans START..STOP
module nco_i2c_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h6A,
  parameter int NUM_CH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_CH-1:0]     enable,
  output logic [2*NUM_CH-1:0]   wave,
  output logic [64*NUM_CH-1:0]  frequency,
  output logic [16*NUM_CH-1:0]  duty_cycle,
  output logic [NUM_CH-1:0]     cfg_update,
  output logic                  busy
);
  localparam int PMAX = 16 * NUM_CH;
  localparam int AW = $clog2(PMAX);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t st;
  logic [2:0] scl_q, sda_q;
  logic [7:0] sh, rd;
  logic [6:0] tx;
  logic [3:0] cnt;
  logic [AW-1:0] ptr, nxt;
  logic [8*PMAX-1:0] shd;
  logic [NUM_CH-1:0] pending;
  logic oe, mack, sda_s, scl_rise, scl_fall, start, stop;
  assign sda = oe ? 1'b0 : 1'bz;
  assign sda_s = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rd = shd[8*ptr +: 8];
  assign nxt = ptr == AW'(PMAX - 1) ? '0 : ptr + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      scl_q <= '1;
      sda_q <= '1;
      sh <= '0;
      tx <= '0;
      cnt <= '0;
      ptr <= '0;
      shd <= '0;
      pending <= '0;
      oe <= 1'b0;
      mack <= 1'b0;
      enable <= '0;
      wave <= '0;
      frequency <= '0;
      duty_cycle <= '0;
      cfg_update <= '0;
      busy <= 1'b0;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
      cfg_update <= '0;
      if (start) begin
        st <= ADDR;
        cnt <= '0;
        oe <= 1'b0;
        busy <= 1'b1;
      end else if (stop) begin
        st <= IDLE;
        oe <= 1'b0;
        busy <= 1'b0;
        cfg_update <= pending;
        pending <= '0;
        for (int n = 0; n < NUM_CH; n++)
          if (pending[n +: 1] != 1'b0) begin
            enable[n +: 1] <= shd[128*n +: 1];
            wave[2*n +: 2] <= shd[128*n+1 +: 2];
            frequency[64*n +: 64] <= shd[128*n+8 +: 64];
            duty_cycle[16*n +: 16] <= shd[128*n+72 +: 16];
          end
      end else if (scl_rise) begin
        if (st == ADDR || st == PTR || st == WR_DATA) begin
          sh <= {sh[6:0], sda_s};
          cnt <= cnt + 1'b1;
        end else if (st == RD_DATA) cnt <= cnt + 1'b1;
        else if (st == RD_ACK) mack <= ~sda_s;
      end else if (scl_fall) begin
        case (st)
          ADDR: if (cnt == 4'd8) begin
            oe <= sh[7:1] == DEV_ADDR;
            st <= sh[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
          end
          ADDR_ACK: begin
            cnt <= '0;
            oe <= sh[0] ? ~rd[7] : 1'b0;
            tx <= rd[6:0];
            st <= sh[0] ? RD_DATA : PTR;
          end
          PTR: if (cnt == 4'd8) begin
            ptr <= AW'(sh % PMAX);
            oe <= 1'b1;
            st <= PTR_ACK;
          end
          PTR_ACK, WR_ACK: begin
            oe <= 1'b0;
            cnt <= '0;
            st <= WR_DATA;
          end
          WR_DATA: if (cnt == 4'd8) begin
            if (ptr[3:0] <= 4'd10) begin
              shd[8*ptr +: 8] <= ptr[3:0] == 4'd0 ? {5'b0, sh[2:0]} : sh;
              pending[(ptr >> 4) +: 1] <= 1'b1;
            end
            ptr <= nxt;
            oe <= 1'b1;
            st <= WR_ACK;
          end
          RD_DATA: if (cnt == 4'd8) begin
            oe <= 1'b0;
            ptr <= nxt;
            st <= RD_ACK;
          end else begin
            oe <= ~tx[6];
            tx <= {tx[5:0], 1'b0};
          end
          RD_ACK: begin
            cnt <= '0;
            oe <= mack & ~rd[7];
            tx <= rd[6:0];
            st <= mack ? RD_DATA : WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nco_i2c_regfile.sv
// tb_nco_i2c_regfile: directed I2C transactions against a byte-level register-map model with per-cycle output compare
`timescale 1ns/1ps
module tb_nco_i2c_regfile;
  localparam int NCH = 2;
  localparam int Q = 200;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_oe = 1'b0;
  wire sda;
  logic [NCH-1:0] enable, cfg_update;
  logic [2*NCH-1:0] wave;
  logic [64*NCH-1:0] frequency;
  logic [16*NCH-1:0] duty_cycle;
  logic busy;
  int nvec = 0, nfail = 0;
  bit chk_en = 1'b0;
  logic [7:0] m_sh [16*NCH];
  int m_ptr;
  logic [NCH-1:0] m_pend, m_en;
  logic [2*NCH-1:0] m_wave;
  logic [64*NCH-1:0] m_freq;
  logic [16*NCH-1:0] m_duty;
  logic [7:0] d [$];
  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  nco_i2c_regfile #(.DEV_ADDR(7'h6A), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .enable(enable), .wave(wave),
    .frequency(frequency), .duty_cycle(duty_cycle), .cfg_update(cfg_update), .busy(busy)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("enable", 128'(enable), 128'(m_en));
      chk("wave", 128'(wave), 128'(m_wave));
      chk("frequency", 128'(frequency), 128'(m_freq));
      chk("duty_cycle", 128'(duty_cycle), 128'(m_duty));
      chk("cfg_update_quiet", 128'(cfg_update), 128'(0));
    end
  task automatic m_reset();
    foreach (m_sh[i]) m_sh[i] = 8'h00;
    m_ptr = 0;
    m_pend = '0;
    m_en = '0;
    m_wave = '0;
    m_freq = '0;
    m_duty = '0;
  endtask
  task automatic m_wr(input logic [7:0] b);
    int ch = m_ptr / 16, off = m_ptr % 16;
    if (off <= 10) begin
      m_sh[m_ptr] = off == 0 ? (b & 8'h07) : b;
      m_pend[ch] = 1'b1;
    end
    m_ptr = (m_ptr + 1) % (16 * NCH);
  endtask
  function automatic logic [7:0] m_rd();
    m_rd = m_sh[m_ptr];
    m_ptr = (m_ptr + 1) % (16 * NCH);
  endfunction
  task automatic m_commit();
    for (int ch = 0; ch < NCH; ch++)
      if (m_pend[ch]) begin
        logic [63:0] f = 64'd0;
        for (int k = 0; k < 8; k++) f = f + (64'(m_sh[16*ch+1+k]) << (8 * k));
        m_en[ch] = m_sh[16*ch][0];
        m_wave[2*ch +: 2] = m_sh[16*ch][2:1];
        m_freq[64*ch +: 64] = f;
        m_duty[16*ch +: 16] = 16'(m_sh[16*ch+9]) + 16'(m_sh[16*ch+10]) * 16'd256;
      end
    m_pend = '0;
  endtask
  task automatic i2c_start();
    m_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl = 1'b0; #20;
    chk("busy_start", 128'(busy), 128'(1));
  endtask
  task automatic i2c_stop(input logic [1:0] lit);
    int np = 0;
    logic [1:0] seen = 2'b00;
    logic [1:0] ep = m_pend;
    chk_en = 1'b0;
    m_oe = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_oe = 1'b0;
    repeat (12) @(negedge clk)
      if (cfg_update != '0) begin
        np++;
        seen = cfg_update;
      end
    chk("cfg_pulse_len", 128'(np), 128'(ep != 0 ? 1 : 0));
    chk("cfg_update", 128'(seen), 128'(ep));
    chk("cfg_update_lit", 128'(seen), 128'(lit));
    m_commit();
    chk("busy_stop", 128'(busy), 128'(0));
    chk_en = 1'b1;
    #Q;
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_oe = ~b[i]; #Q;
      scl = 1'b1; #Q;
      scl = 1'b0; #20;
    end
    m_oe = 1'b0; #Q;
    scl = 1'b1; #(Q/2);
    ack = sda === 1'b0; #(Q/2);
    scl = 1'b0; #20;
  endtask
  task automatic rbyte(output logic [7:0] b, input logic ack);
    m_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #(Q/2);
      b[i] = sda !== 1'b0; #(Q/2);
      scl = 1'b0; #20;
    end
    m_oe = ack; #Q;
    scl = 1'b1; #Q;
    scl = 1'b0; #20;
    m_oe = 1'b0;
  endtask
  task automatic send_raw(input logic [7:0] b, input logic exp_ack, input string n);
    logic a;
    wbyte(b, a);
    chk(n, 128'(a), 128'(exp_ack));
  endtask
  task automatic send_addr(input logic [7:0] b);
    send_raw(b, b[7:1] == 7'h6A, "addr_ack");
  endtask
  task automatic send_ptr(input logic [7:0] b);
    send_raw(b, 1'b1, "ptr_ack");
    m_ptr = b % (16 * NCH);
  endtask
  task automatic send_data(input logic [7:0] b);
    send_raw(b, 1'b1, "data_ack");
    m_wr(b);
  endtask
  task automatic recv(input logic ack, input logic [7:0] lit);
    logic [7:0] g;
    rbyte(g, ack);
    chk("rd_byte", 128'(g), 128'(m_rd()));
    chk("rd_byte_lit", 128'(g), 128'(lit));
  endtask
  initial begin
    m_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_outputs", 128'({enable, wave, duty_cycle}), 128'(0));
    chk("rst_frequency", 128'(frequency), 128'(0));
    chk("rst_cfg_busy", 128'({cfg_update, busy}), 128'(0));
    chk("rst_sda", 128'(sda), 128'(1));
    rst = 1'b0;
    chk_en = 1'b1;
    #Q;
    i2c_start();
    send_addr(8'hD4);
    send_ptr(8'h00);
    d = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    foreach (d[i]) send_data(d[i]);
    i2c_stop(2'b01);
    chk("lit_en0", 128'(enable[0]), 128'(1));
    chk("lit_wave0", 128'(wave[1:0]), 128'(2'b01));
    chk("lit_freq0", 128'(frequency[63:0]), 128'(64'h12345678));
    chk("lit_duty0", 128'(duty_cycle[15:0]), 128'(16'h8000));
    i2c_start();
    send_addr(8'hAA);
    send_raw(8'h00, 1'b0, "foreign_data_ack");
    chk("busy_foreign", 128'(busy), 128'(1));
    i2c_stop(2'b00);
    i2c_start();
    send_addr(8'hD4);
    send_ptr(8'h01);
    i2c_start();
    send_addr(8'hD5);
    recv(1'b1, 8'h78);
    recv(1'b1, 8'h56);
    recv(1'b1, 8'h34);
    recv(1'b0, 8'h12);
    #Q;
    chk("sda_after_nack", 128'(sda), 128'(1));
    i2c_stop(2'b00);
    i2c_start();
    send_addr(8'hD4);
    send_ptr(8'h1F);
    send_data(8'hFF);
    send_data(8'h05);
    i2c_stop(2'b01);
    chk("lit_wrap_en0", 128'(enable[0]), 128'(1));
    chk("lit_wrap_wave0", 128'(wave[1:0]), 128'(2'b10));
    chk("lit_wrap_freq0", 128'(frequency[63:0]), 128'(64'h12345678));
    i2c_start();
    send_addr(8'hD4);
    send_ptr(8'h10);
    d = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (d[i]) send_data(d[i]);
    chk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 128'({enable, wave, duty_cycle}), 128'(0));
    chk("mid_rst_frequency", 128'(frequency), 128'(0));
    chk("mid_rst_cfg_busy", 128'({cfg_update, busy}), 128'(0));
    chk("mid_rst_sda", 128'(sda), 128'(1));
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    send_raw(8'hD4, 1'b0, "no_start_ack");
    i2c_stop(2'b00);
    i2c_start();
    send_addr(8'hD4);
    send_ptr(8'h10);
    d = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    foreach (d[i]) send_data(d[i]);
    i2c_stop(2'b10);
    chk("lit_en", 128'(enable), 128'(2'b10));
    chk("lit_wave", 128'(wave), 128'(4'b0100));
    chk("lit_freq", 128'(frequency), {64'h12345678, 64'h0});
    chk("lit_duty", 128'(duty_cycle), 128'(32'h80000000));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
